pc_seq: RTL and testbench

Program-counter sequencer for the fetch stage. It sits directly upstream of the enable-gated 32-bit register and the instruction memory, and it produces the next PC value plus the load enable for that register. It selects among sequential, branch, jump and jump-register targets, detects misaligned targets, halts into a trap state on a misaligned target, and counts PC advances.

---
 rtl/pc_seq.sv | 134 +++++++++++++
 tb/tb_pc_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch stage: picks the next PC, drives the
// downstream register load enable, traps on misaligned targets and counts advances.
// Optional branch-source history port is enabled with `define PC_SEQ_HIST_EN.
module pc_seq #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h00000080),
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             branch,
  input  logic             zero,
  input  logic [15:0]      imm,
  input  logic             jump,
  input  logic [25:0]      jtarget,
  input  logic             jr,
  input  logic [WIDTH-1:0] rs,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pcp4,
  output logic             ld,
  output logic             trap,
  output logic [CNT_W-1:0] count
`ifdef PC_SEQ_HIST_EN
  ,
  output logic [WIDTH-1:0] last_tgt,
  output logic             last_vld
`endif
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             trap_nxt;

  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jmp_tgt;
  logic             taken;
  logic             nonseq;
  logic             misal;

  assign pcp4   = pc + WIDTH'(4);
  assign br_tgt = pcp4 + {{(WIDTH-18){imm[15]}}, imm, 2'b00};
  assign taken  = branch & zero;
  assign nonseq = jr | jump | taken;

  // Jumps keep the top region bits of pc+4; at the minimum width there are none.
  generate
    if (WIDTH > 28) begin : g_jmp_region
      assign jmp_tgt = {pcp4[WIDTH-1:28], jtarget, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_tgt = {jtarget, 2'b00};
    end
  endgenerate

  always_comb begin
    target = pcp4;
    if (jr) begin
      target = rs;
    end else if (jump) begin
      target = jmp_tgt;
    end else if (taken) begin
      target = br_tgt;
    end
  end

  assign misal = |target[1:0];
  assign ld    = !reset && enable && (state == RUN) && !misal;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    trap_nxt  = trap;
    case (state)
      RUN: begin
        if (enable) begin
          if (misal) begin
            state_nxt = TRAP;
            trap_nxt  = 1'b1;
          end else begin
            pc_nxt    = target;
            count_nxt = (count == '1) ? count : count + CNT_W'(1);
          end
        end
      end
      TRAP: begin
        state_nxt = TRAP;
      end
      default: begin
        state_nxt = TRAP;
        trap_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      pc    <= RESET_PC;
      count <= '0;
      trap  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      trap  <= trap_nxt;
    end
  end

`ifdef PC_SEQ_HIST_EN
  // Records the source address of every redirecting advance; ld already excludes TRAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_tgt <= '0;
      last_vld <= 1'b0;
    end else if (ld && nonseq) begin
      last_tgt <= pc;
      last_vld <= 1'b1;
    end
  end
`else
  logic unused_hist;
  assign unused_hist = nonseq;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios followed by random stimulus,
// compared against a behavioural model; a CNT_W=2 instance shares the stimulus.
module tb_pc_seq;

  localparam logic [31:0] RST_PC = 32'h00000080;

  logic        clk = 1'b0;
  logic        reset, enable, branch, zero, jump, jr;
  logic [15:0] imm;
  logic [25:0] jtarget;
  logic [31:0] rs;

  logic [31:0] pc, pcp4, pc2, pcp4b;
  logic        ld, trap, ld2, trap2;
  logic [15:0] count;
  logic [1:0]  count2;
`ifdef PC_SEQ_HIST_EN
  logic [31:0] last_tgt, last_tgt2;
  logic        last_vld, last_vld2;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mpc, mlt;
  bit          mtrap, mlv, mvalid;
  int          mcnt;

  pc_seq #(.WIDTH(32), .RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .branch(branch), .zero(zero),
    .imm(imm), .jump(jump), .jtarget(jtarget), .jr(jr), .rs(rs),
    .pc(pc), .pcp4(pcp4), .ld(ld), .trap(trap), .count(count)
`ifdef PC_SEQ_HIST_EN
    , .last_tgt(last_tgt), .last_vld(last_vld)
`endif
  );

  pc_seq #(.WIDTH(32), .RESET_PC(RST_PC), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .branch(branch), .zero(zero),
    .imm(imm), .jump(jump), .jtarget(jtarget), .jr(jr), .rs(rs),
    .pc(pc2), .pcp4(pcp4b), .ld(ld2), .trap(trap2), .count(count2)
`ifdef PC_SEQ_HIST_EN
    , .last_tgt(last_tgt2), .last_vld(last_vld2)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next PC as described by the selection rules, in plain arithmetic.
  function automatic logic [31:0] modelTarget();
    int off;
    if (jr) return rs;
    if (jump) return ((mpc + 32'd4) & 32'hF000_0000) + ({6'd0, jtarget} * 32'd4);
    if (branch && zero) begin
      off = int'($signed(imm));
      return mpc + 32'd4 + 32'(off * 4);
    end
    return mpc + 32'd4;
  endfunction

  task automatic applyStimulus(input bit r, input bit e, input bit b, input bit z,
                               input logic [15:0] i, input bit j, input logic [25:0] jt,
                               input bit jrr, input logic [31:0] rsv);
    logic [31:0] tgt;
    bit          mis;
    reset = r; enable = e; branch = b; zero = z; imm = i;
    jump = j; jtarget = jt; jr = jrr; rs = rsv;
    #1;
    tgt = modelTarget();
    mis = (tgt[1:0] != 2'b00);
    if (mvalid) begin
      checkOutput("pcp4", {32'd0, pcp4}, {32'd0, mpc + 32'd4});
      checkOutput("ld", {63'd0, ld}, {63'd0, (!r && e && !mtrap && !mis)});
    end else if (r) begin
      checkOutput("ld_in_reset", {63'd0, ld}, 64'd0);
    end
    @(posedge clk);
    if (r) begin
      mpc = RST_PC; mtrap = 0; mcnt = 0; mlv = 0; mlt = '0; mvalid = 1;
    end else if (mvalid && !mtrap && e) begin
      if (mis) begin
        mtrap = 1;
      end else begin
        if (jrr || j || (b && z)) begin
          mlt = mpc;
          mlv = 1;
        end
        mpc = tgt;
        mcnt++;
      end
    end
    #1;
    if (mvalid) begin
      checkOutput("pc", {32'd0, pc}, {32'd0, mpc});
      checkOutput("trap", {63'd0, trap}, {63'd0, mtrap});
      checkOutput("count", {48'd0, count}, 64'((mcnt > 65535) ? 65535 : mcnt));
      checkOutput("count_sat2", {62'd0, count2}, 64'((mcnt > 3) ? 3 : mcnt));
`ifdef PC_SEQ_HIST_EN
      checkOutput("last_tgt", {32'd0, last_tgt}, {32'd0, mlt});
      checkOutput("last_vld", {63'd0, last_vld}, {63'd0, mlv});
`endif
    end
  endtask

  initial begin
    bit          rr, ee, bb, zz, jj, jrv;
    logic [15:0] ii;
    logic [25:0] jtv;
    logic [31:0] rsv;
    mvalid = 0; mtrap = 0; mcnt = 0; mlv = 0; mlt = '0; mpc = '0;
    reset = 1; enable = 0; branch = 0; zero = 0; imm = '0;
    jump = 0; jtarget = '0; jr = 0; rs = '0;
    #2;

    applyStimulus(1, 0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    checkOutput("tp1_reset_pc", {32'd0, pc}, 64'h80);
    repeat (3) applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    checkOutput("tp1_pc", {32'd0, pc}, 64'h8C);
    checkOutput("tp1_count", {48'd0, count}, 64'd3);

    repeat (2) applyStimulus(0, 0, 1, 1, 16'h0010, 1, 26'h123, 0, 32'h0);
    checkOutput("tp2_stall_pc", {32'd0, pc}, 64'h8C);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    checkOutput("tp2_pc", {32'd0, pc}, 64'h90);

    applyStimulus(0, 1, 1, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0);
    checkOutput("tp3_branch", {32'd0, pc}, 64'h84);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h90);
    applyStimulus(0, 1, 1, 0, 16'hFFFC, 0, 26'h0, 0, 32'h0);
    checkOutput("tp3_not_taken", {32'd0, pc}, 64'h94);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h90);
    applyStimulus(0, 1, 1, 1, 16'hFFFC, 1, 26'h40, 0, 32'h0);
    checkOutput("tp3_jump_wins", {32'd0, pc}, 64'h100);

    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h202);
    checkOutput("tp4_trap", {63'd0, trap}, 64'd1);
    checkOutput("tp4_pc_hold", {32'd0, pc}, 64'h100);
    repeat (3) applyStimulus(0, 1, 0, 0, 16'h0, 1, 26'h55, 0, 32'h0);
    checkOutput("tp4_frozen_pc", {32'd0, pc}, 64'h100);
    applyStimulus(1, 1, 0, 0, 16'h0, 1, 26'h55, 0, 32'h0);
    checkOutput("tp4_reset_trap", {63'd0, trap}, 64'd0);

    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    checkOutput("tp5_wrap", {32'd0, pc}, 64'h0);
    repeat (5) applyStimulus(0, 1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0);
    checkOutput("tp5_sat", {62'd0, count2}, 64'd3);

    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 29) == 0);
      ee  = ($urandom_range(0, 3) != 0);
      bb  = $urandom_range(0, 1) == 1;
      zz  = $urandom_range(0, 1) == 1;
      ii  = 16'($urandom);
      jj  = ($urandom_range(0, 4) == 0);
      jtv = 26'($urandom);
      jrv = ($urandom_range(0, 7) == 0);
      rsv = $urandom;
      if ($urandom_range(0, 3) != 0) rsv[1:0] = 2'b00;
      applyStimulus(rr, ee, bb, zz, ii, jj, jtv, jrv, rsv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
